fc_rx_credit_alloc: RTL and testbench
=====================================

Name: fc_rx_credit_alloc

Overview:
Receiver-side flow-control credit allocator, one per link, at the RX buffer / DLL boundary.
- Holds the Credits-Allocated (CA) counters for P, NP and Cpl.
- Advances them as the RX buffer frees entries.
- Sequences InitFC, event UpdateFC and periodic UpdateFC requests toward the DLLP transmitter.
- The payload fields match what the link partner's TX credit-limit tracker consumes: hdr/data credit, init/update flag and credit type.

Parameters:
PH_INIT, 8'd32, initial posted-header credits advertised
PD_INIT, 12'd256, initial posted-data credits
NPH_INIT, 8'd16, initial non-posted-header credits
CPLH_INIT, 8'd32, initial completion-header credits
CPLD_INIT, 12'd256, initial completion-data credits
UPDATE_INTERVAL, 1024, cycles between periodic UpdateFC refreshes in ACTIVE (>=4)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
link_up_i  in  1  link trained; low = link down
free_valid_i  in  1  RX buffer released one TLP this cycle
free_type_i  in  2  type of released TLP: 00 P, 01 NP, 10 Cpl, 11 ignored
free_data_i  in  12  data credits released with it (ignored for NP)
dllp_valid_o  out  1  FC DLLP request valid
dllp_ready_i  in  1  DLLP transmitter accepts request
dllp_is_init_o  out  1  request is InitFC
dllp_is_update_o  out  1  request is UpdateFC
dllp_type_o  out  2  credit type of request (00 P, 01 NP, 10 Cpl)
dllp_hdr_credit_o  out  8  advertised header CA
dllp_data_credit_o  out  12  advertised data CA (0 for NP)
init_done_o  out  1  InitFC sequence complete

Behaviour:
Clock and reset:
- One clock. Reset is asynchronous and active-high.
- Reset values: dllp_valid_o=0, dllp_is_init_o=0, dllp_is_update_o=0, dllp_type_o=00, dllp_hdr_credit_o=0, dllp_data_credit_o=0, init_done_o=0.
- Also on reset: CA counters = *_INIT, pending flags = 0, timer = 0, state = IDLE.
- All outputs are registered.

CA counters:
- ca_ph/ca_nph/ca_cplh are 8 bits; ca_pd/ca_cpld are 12 bits. All arithmetic is modulo 2^width and wraps silently (FF->00, FFF->000).
- free_valid_i with type P: ca_ph+=1 and ca_pd+=free_data_i.
- Type NP: ca_nph+=1; free_data_i is ignored.
- Type Cpl: ca_cplh+=1 and ca_cpld+=free_data_i.
- Type 11: no effect.
- Counters update the cycle after the free event.
- Free events in IDLE or INIT are still counted.

Handshake:
- A transfer occurs when dllp_valid_o && dllp_ready_i.
- While dllp_valid_o=1 and dllp_ready_i=0, all dllp_* fields hold stable.
- The payload is snapshotted from the CA registers in the cycle valid rises.
- After an accept, the next request can assert in the following cycle at the earliest.

FSM states:
- IDLE: valid=0. Enter INIT_P the cycle after link_up_i=1.
- INIT_P, INIT_NP, INIT_CPL: issue an InitFC for P, then NP, then Cpl, with is_init=1, is_update=0.
  - On accept, advance to the next state.
  - After the Cpl accept: init_done_o=1 from the next cycle, go to ACTIVE, timer=0, all pending flags=0.
- ACTIVE: issue an UpdateFC (is_update=1) for any set pending flag.
  - Priority P > NP > Cpl.
  - A flag clears on accept of its type.
- Pending flags in ACTIVE:
  - A free event of type t sets pend[t].
  - A free event of type t in the same cycle as the accept of type t leaves pend[t] set. That request carries the pre-event CA, so a follow-up update is required.
- Timer (ACTIVE only):
  - Counts every cycle; on reaching UPDATE_INTERVAL-1 it sets all three pend flags and wraps to 0.
  - Timer expiry and an accept in the same cycle: expiry wins, so the flag stays set.

Link down:
- link_up_i=0 in any state forces IDLE the next cycle.
- This aborts any in-flight request immediately; this is the only allowed violation of the stable-until-accept rule.
- It also clears init_done_o and pending flags, and reloads all CA to *_INIT.
- A later link-up restarts the InitFC sequence.

Latency:
- link_up_i rising at cycle N gives dllp_valid_o=1 (InitFC-P) at cycle N+2. IDLE->INIT_P registers at N+1; valid is registered at N+2.
- A free event in ACTIVE at cycle N gives valid at N+2 at the earliest, with CA already including the event.

Test Plan:
1. Reset, then link_up_i=1 with dllp_ready_i=1 -> three accepted DLLPs in order, all with is_init=1:
   - P: hdr=0x20, data=0x100
   - NP: hdr=0x10, data=0
   - Cpl: hdr=0x20, data=0x100
   Then init_done_o=1.
2. In ACTIVE, one P free with free_data_i=4 -> one UpdateFC with type=00, hdr=0x21, data=0x104. No other requests before the timer expires.
3. Hold dllp_ready_i=0 for 5 cycles during UpdateFC-Cpl while two Cpl frees occur -> payload stays stable (hdr=0x20). After accept, a second UpdateFC-Cpl follows with hdr=0x22.
4. Frees of type NP and P in consecutive cycles with ready=1 -> UpdateFC P is issued before NP. Type-11 frees produce no request.
5. Apply 224 P frees, each with free_data_i=16 -> ca_ph wraps 0x20->0x00 and ca_pd wraps to 0x100+0xE00=0xF00. Further frees wrap 0xFFF->0x000 with no stall.
6. Drop link_up_i mid-request with ready=0 -> dllp_valid_o=0 and init_done_o=0 next cycle. Relinking re-issues InitFC with the *_INIT values.

Source files
------------

// File: rtl/fc_rx_credit_alloc.sv
// Receiver-side flow-control credit allocator.
// Tracks Credits-Allocated counters for P/NP/Cpl, runs the InitFC sequence after
// link-up, then issues UpdateFC DLLP requests on buffer release and on a refresh timer.
module fc_rx_credit_alloc #(
  parameter logic [7:0]  PH_INIT         = 8'd32,
  parameter logic [11:0] PD_INIT         = 12'd256,
  parameter logic [7:0]  NPH_INIT        = 8'd16,
  parameter logic [7:0]  CPLH_INIT       = 8'd32,
  parameter logic [11:0] CPLD_INIT       = 12'd256,
  parameter int unsigned UPDATE_INTERVAL = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        link_up_i,
  input  logic        free_valid_i,
  input  logic [1:0]  free_type_i,
  input  logic [11:0] free_data_i,
  output logic        dllp_valid_o,
  input  logic        dllp_ready_i,
  output logic        dllp_is_init_o,
  output logic        dllp_is_update_o,
  output logic [1:0]  dllp_type_o,
  output logic [7:0]  dllp_hdr_credit_o,
  output logic [11:0] dllp_data_credit_o,
  output logic        init_done_o
);

  localparam logic [1:0] TypeP   = 2'b00;
  localparam logic [1:0] TypeNp  = 2'b01;
  localparam logic [1:0] TypeCpl = 2'b10;

  localparam int unsigned TimerW = $clog2(UPDATE_INTERVAL);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(UPDATE_INTERVAL - 1);

  typedef enum logic [2:0] {
    StIdle,
    StInitP,
    StInitNp,
    StInitCpl,
    StActive
  } state_e;

  state_e state_q, state_d;

  // Credits-Allocated counters; all wrap modulo their width.
  logic [7:0]  ca_ph_q,   ca_ph_d;
  logic [11:0] ca_pd_q,   ca_pd_d;
  logic [7:0]  ca_nph_q,  ca_nph_d;
  logic [7:0]  ca_cplh_q, ca_cplh_d;
  logic [11:0] ca_cpld_q, ca_cpld_d;

  // Pending UpdateFC flags, bit 0 = P, bit 1 = NP, bit 2 = Cpl.
  logic [2:0] pend_q, pend_d;
  // The in-flight request's snapshot is out of date: a free of its type arrived
  // after launch, so the accept must not clear the pending flag.
  logic       stale_q, stale_d;
  logic [TimerW-1:0] timer_q, timer_d;

  logic        valid_q,     valid_d;
  logic        is_init_q,   is_init_d;
  logic        is_update_q, is_update_d;
  logic [1:0]  type_q,      type_d;
  logic [7:0]  hdr_q,       hdr_d;
  logic [11:0] data_q,      data_d;
  logic        init_done_q, init_done_d;

  logic [2:0] free_hit;
  logic [2:0] inflight_oh;
  logic       accept;
  logic       timer_expire;
  logic       launch;
  logic [1:0] launch_type;

  assign accept       = valid_q && dllp_ready_i;
  assign timer_expire = (state_q == StActive) && (timer_q == TimerMax);

  // Decode the free event into a per-type one-hot; type 11 decodes to nothing.
  always_comb begin
    free_hit = 3'b000;
    if (free_valid_i) begin
      case (free_type_i)
        TypeP:   free_hit = 3'b001;
        TypeNp:  free_hit = 3'b010;
        TypeCpl: free_hit = 3'b100;
        default: free_hit = 3'b000;
      endcase
    end
  end

  // One-hot of the credit type currently held in the request register.
  always_comb begin
    inflight_oh = 3'b000;
    case (type_q)
      TypeP:   inflight_oh = 3'b001;
      TypeNp:  inflight_oh = 3'b010;
      TypeCpl: inflight_oh = 3'b100;
      default: inflight_oh = 3'b000;
    endcase
  end

  // CA counter next-state: reload while the link is down, else accumulate frees.
  always_comb begin
    ca_ph_d   = ca_ph_q;
    ca_pd_d   = ca_pd_q;
    ca_nph_d  = ca_nph_q;
    ca_cplh_d = ca_cplh_q;
    ca_cpld_d = ca_cpld_q;
    if (!link_up_i) begin
      ca_ph_d   = PH_INIT;
      ca_pd_d   = PD_INIT;
      ca_nph_d  = NPH_INIT;
      ca_cplh_d = CPLH_INIT;
      ca_cpld_d = CPLD_INIT;
    end else begin
      if (free_hit[0]) begin
        ca_ph_d = ca_ph_q + 8'd1;
        ca_pd_d = ca_pd_q + free_data_i;
      end
      if (free_hit[1]) begin
        ca_nph_d = ca_nph_q + 8'd1;
      end
      if (free_hit[2]) begin
        ca_cplh_d = ca_cplh_q + 8'd1;
        ca_cpld_d = ca_cpld_q + free_data_i;
      end
    end
  end

  // FSM next-state, pending/timer bookkeeping and DLLP request register next-state.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    is_init_d   = is_init_q;
    is_update_d = is_update_q;
    type_d      = type_q;
    hdr_d       = hdr_q;
    data_d      = data_q;
    init_done_d = init_done_q;
    pend_d      = pend_q;
    stale_d     = stale_q;
    timer_d     = timer_q;
    launch      = 1'b0;
    launch_type = TypeP;

    if (valid_q && |(free_hit & inflight_oh)) begin
      stale_d = 1'b1;
    end
    if (accept) begin
      valid_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        timer_d = '0;
        if (link_up_i) begin
          state_d = StInitP;
        end
      end
      StInitP: begin
        if (accept) begin
          state_d = StInitNp;
        end else if (!valid_q) begin
          launch      = 1'b1;
          launch_type = TypeP;
        end
      end
      StInitNp: begin
        if (accept) begin
          state_d = StInitCpl;
        end else if (!valid_q) begin
          launch      = 1'b1;
          launch_type = TypeNp;
        end
      end
      StInitCpl: begin
        if (accept) begin
          state_d     = StActive;
          init_done_d = 1'b1;
          timer_d     = '0;
          pend_d      = 3'b000;
        end else if (!valid_q) begin
          launch      = 1'b1;
          launch_type = TypeCpl;
        end
      end
      StActive: begin
        timer_d = timer_expire ? '0 : timer_q + TimerW'(1);
        // Clear on accept first so a same-cycle free or timer expiry re-sets the flag.
        if (accept && !stale_q) begin
          pend_d = pend_q & ~inflight_oh;
        end
        pend_d = pend_d | free_hit;
        if (timer_expire) begin
          pend_d = 3'b111;
        end
        if (!valid_q) begin
          if (pend_q[0]) begin
            launch      = 1'b1;
            launch_type = TypeP;
          end else if (pend_q[1]) begin
            launch      = 1'b1;
            launch_type = TypeNp;
          end else if (pend_q[2]) begin
            launch      = 1'b1;
            launch_type = TypeCpl;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Snapshot the payload from the CA registers as the request is raised.
    if (launch) begin
      valid_d     = 1'b1;
      is_init_d   = (state_q != StActive);
      is_update_d = (state_q == StActive);
      type_d      = launch_type;
      stale_d     = 1'b0;
      case (launch_type)
        TypeNp: begin
          hdr_d  = ca_nph_q;
          data_d = 12'd0;
        end
        TypeCpl: begin
          hdr_d  = ca_cplh_q;
          data_d = ca_cpld_q;
        end
        default: begin
          hdr_d  = ca_ph_q;
          data_d = ca_pd_q;
        end
      endcase
    end

    // Link down aborts everything, including an unaccepted request.
    if (!link_up_i) begin
      state_d     = StIdle;
      valid_d     = 1'b0;
      is_init_d   = 1'b0;
      is_update_d = 1'b0;
      type_d      = TypeP;
      hdr_d       = 8'd0;
      data_d      = 12'd0;
      init_done_d = 1'b0;
      pend_d      = 3'b000;
      stale_d     = 1'b0;
      timer_d     = '0;
    end
  end

  // State, counters and request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      ca_ph_q     <= PH_INIT;
      ca_pd_q     <= PD_INIT;
      ca_nph_q    <= NPH_INIT;
      ca_cplh_q   <= CPLH_INIT;
      ca_cpld_q   <= CPLD_INIT;
      pend_q      <= 3'b000;
      stale_q     <= 1'b0;
      timer_q     <= '0;
      valid_q     <= 1'b0;
      is_init_q   <= 1'b0;
      is_update_q <= 1'b0;
      type_q      <= TypeP;
      hdr_q       <= 8'd0;
      data_q      <= 12'd0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ca_ph_q     <= ca_ph_d;
      ca_pd_q     <= ca_pd_d;
      ca_nph_q    <= ca_nph_d;
      ca_cplh_q   <= ca_cplh_d;
      ca_cpld_q   <= ca_cpld_d;
      pend_q      <= pend_d;
      stale_q     <= stale_d;
      timer_q     <= timer_d;
      valid_q     <= valid_d;
      is_init_q   <= is_init_d;
      is_update_q <= is_update_d;
      type_q      <= type_d;
      hdr_q       <= hdr_d;
      data_q      <= data_d;
      init_done_q <= init_done_d;
    end
  end

  assign dllp_valid_o       = valid_q;
  assign dllp_is_init_o     = is_init_q;
  assign dllp_is_update_o   = is_update_q;
  assign dllp_type_o        = type_q;
  assign dllp_hdr_credit_o  = hdr_q;
  assign dllp_data_credit_o = data_q;
  assign init_done_o        = init_done_q;

endmodule

// File: tb/tb_fc_rx_credit_alloc.sv
// Directed bench for fc_rx_credit_alloc: InitFC sequence, UpdateFC on free,
// backpressure stability, priority, counter wrap and link-down abort.
module tb_fc_rx_credit_alloc;

  logic        clk;
  logic        rst;
  logic        link_up_i;
  logic        free_valid_i;
  logic [1:0]  free_type_i;
  logic [11:0] free_data_i;
  logic        dllp_valid_o;
  logic        dllp_ready_i;
  logic        dllp_is_init_o;
  logic        dllp_is_update_o;
  logic [1:0]  dllp_type_o;
  logic [7:0]  dllp_hdr_credit_o;
  logic [11:0] dllp_data_credit_o;
  logic        init_done_o;

  int n_checks = 0;
  int n_fails  = 0;

  fc_rx_credit_alloc dut (
    .clk                (clk),
    .rst                (rst),
    .link_up_i          (link_up_i),
    .free_valid_i       (free_valid_i),
    .free_type_i        (free_type_i),
    .free_data_i        (free_data_i),
    .dllp_valid_o       (dllp_valid_o),
    .dllp_ready_i       (dllp_ready_i),
    .dllp_is_init_o     (dllp_is_init_o),
    .dllp_is_update_o   (dllp_is_update_o),
    .dllp_type_o        (dllp_type_o),
    .dllp_hdr_credit_o  (dllp_hdr_credit_o),
    .dllp_data_credit_o (dllp_data_credit_o),
    .init_done_o        (init_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic free(input logic [1:0] ty, input logic [11:0] d);
    free_valid_i = 1'b1;
    free_type_i  = ty;
    free_data_i  = d;
    step();
    free_valid_i = 1'b0;
    free_type_i  = 2'b00;
    free_data_i  = 12'd0;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    for (int i = 0; i < budget && dllp_valid_o !== 1'b1; i++) step();
    check({tag, " valid"}, 32'(dllp_valid_o), 32'd1);
  endtask

  task automatic expect_dllp(input string tag, input logic init, input logic upd,
                             input logic [1:0] ty, input logic [7:0] hdr,
                             input logic [11:0] data, input int budget);
    wait_valid(tag, budget);
    check({tag, " is_init"},   32'(dllp_is_init_o),     32'(init));
    check({tag, " is_update"}, 32'(dllp_is_update_o),   32'(upd));
    check({tag, " type"},      32'(dllp_type_o),        32'(ty));
    check({tag, " hdr"},       32'(dllp_hdr_credit_o),  32'(hdr));
    check({tag, " data"},      32'(dllp_data_credit_o), 32'(data));
  endtask

  task automatic quiet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      check(tag, 32'(dllp_valid_o), 32'd0);
      step();
    end
  endtask

  initial begin
    rst          = 1'b1;
    link_up_i    = 1'b0;
    free_valid_i = 1'b0;
    free_type_i  = 2'b00;
    free_data_i  = 12'd0;
    dllp_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset values
    check("rst valid",     32'(dllp_valid_o),       32'd0);
    check("rst is_init",   32'(dllp_is_init_o),     32'd0);
    check("rst is_update", 32'(dllp_is_update_o),   32'd0);
    check("rst type",      32'(dllp_type_o),        32'd0);
    check("rst hdr",       32'(dllp_hdr_credit_o),  32'd0);
    check("rst data",      32'(dllp_data_credit_o), 32'd0);
    check("rst init_done", 32'(init_done_o),        32'd0);
    rst = 1'b0;
    step();

    // 1: InitFC sequence, valid two cycles after link-up
    link_up_i    = 1'b1;
    dllp_ready_i = 1'b1;
    step();
    check("t1 latency N+1", 32'(dllp_valid_o), 32'd0);
    step();
    check("t1 latency N+2", 32'(dllp_valid_o), 32'd1);
    expect_dllp("t1 init P", 1'b1, 1'b0, 2'b00, 8'h20, 12'h100, 4);
    step();
    check("t1 init_done early", 32'(init_done_o), 32'd0);
    expect_dllp("t1 init NP", 1'b1, 1'b0, 2'b01, 8'h10, 12'h000, 4);
    step();
    expect_dllp("t1 init Cpl", 1'b1, 1'b0, 2'b10, 8'h20, 12'h100, 4);
    step();
    check("t1 init_done", 32'(init_done_o), 32'd1);

    // 2: one P free -> one UpdateFC-P at N+2 carrying the new CA
    free(2'b00, 12'd4);
    check("t2 latency N+1", 32'(dllp_valid_o), 32'd0);
    step();
    expect_dllp("t2 upd P", 1'b0, 1'b1, 2'b00, 8'h21, 12'h104, 1);
    step();
    quiet("t2 quiet", 50);

    // 3: timer refresh P, NP, Cpl; Cpl held under backpressure while Cpl frees arrive
    expect_dllp("t3 timer P", 1'b0, 1'b1, 2'b00, 8'h21, 12'h104, 1100);
    step();
    expect_dllp("t3 timer NP", 1'b0, 1'b1, 2'b01, 8'h10, 12'h000, 4);
    step();
    dllp_ready_i = 1'b0;
    expect_dllp("t3 timer Cpl", 1'b0, 1'b1, 2'b10, 8'h20, 12'h100, 4);
    for (int i = 0; i < 5; i++) begin
      if (i == 1 || i == 3) free(2'b10, 12'd8);
      else step();
      check("t3 hold valid", 32'(dllp_valid_o),       32'd1);
      check("t3 hold hdr",   32'(dllp_hdr_credit_o),  32'h20);
      check("t3 hold data",  32'(dllp_data_credit_o), 32'h100);
    end
    dllp_ready_i = 1'b1;
    step();
    expect_dllp("t3 follow Cpl", 1'b0, 1'b1, 2'b10, 8'h22, 12'h110, 4);
    step();
    quiet("t3 quiet", 10);

    // 4: P then NP frees in consecutive cycles; type 11 has no effect
    free(2'b00, 12'd2);
    free(2'b01, 12'h7FF);
    expect_dllp("t4 upd P", 1'b0, 1'b1, 2'b00, 8'h22, 12'h106, 4);
    step();
    expect_dllp("t4 upd NP", 1'b0, 1'b1, 2'b01, 8'h11, 12'h000, 4);
    step();
    quiet("t4 pre quiet", 3);
    for (int i = 0; i < 3; i++) free(2'b11, 12'h050);
    quiet("t4 type11 quiet", 10);
    free(2'b00, 12'd0);
    expect_dllp("t4 upd P after t11", 1'b0, 1'b1, 2'b00, 8'h23, 12'h106, 4);
    step();

    // 6: link drop aborts a held request and restarts InitFC from *_INIT
    dllp_ready_i = 1'b0;
    free(2'b00, 12'd1);
    expect_dllp("t6 held P", 1'b0, 1'b1, 2'b00, 8'h24, 12'h107, 4);
    link_up_i = 1'b0;
    step();
    check("t6 abort valid",     32'(dllp_valid_o), 32'd0);
    check("t6 abort init_done", 32'(init_done_o),  32'd0);
    step();
    check("t6 idle valid", 32'(dllp_valid_o), 32'd0);
    link_up_i    = 1'b1;
    dllp_ready_i = 1'b1;
    expect_dllp("t6 reinit P", 1'b1, 1'b0, 2'b00, 8'h20, 12'h100, 6);
    step();
    expect_dllp("t6 reinit NP", 1'b1, 1'b0, 2'b01, 8'h10, 12'h000, 4);
    step();
    expect_dllp("t6 reinit Cpl", 1'b1, 1'b0, 2'b10, 8'h20, 12'h100, 4);
    step();
    check("t6 init_done", 32'(init_done_o), 32'd1);

    // 5: 224 P frees of 16 wrap ca_ph to 0x00 and ca_pd to 0xF00, then 0xFFF -> 0x000
    dllp_ready_i = 1'b0;
    for (int i = 0; i < 224; i++) free(2'b00, 12'd16);
    check("t5 held valid", 32'(dllp_valid_o),       32'd1);
    check("t5 held hdr",   32'(dllp_hdr_credit_o),  32'h21);
    check("t5 held data",  32'(dllp_data_credit_o), 32'h110);
    dllp_ready_i = 1'b1;
    step();
    expect_dllp("t5 wrap hdr", 1'b0, 1'b1, 2'b00, 8'h00, 12'hF00, 4);
    step();
    free(2'b00, 12'h0FF);
    expect_dllp("t5 data FFF", 1'b0, 1'b1, 2'b00, 8'h01, 12'hFFF, 4);
    step();
    free(2'b00, 12'h001);
    expect_dllp("t5 data wrap", 1'b0, 1'b1, 2'b00, 8'h02, 12'h000, 4);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
